// File: rtl/seg16_pkg.sv
// Shared 16-segment letter definitions: code width, blank/max codes, controller states.
// Used by the scroll controller and by any message source feeding it.
package seg16_pkg;

    localparam int LETTER_W = 6;

    typedef logic [LETTER_W-1:0] letter_t;

    localparam letter_t LETTER_BLANK = 6'd0;
    localparam letter_t LETTER_MAX   = 6'd52;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Codes above the alphabet have no glyph in the decoder; show them as blank.
    function automatic letter_t sanitize_letter(input letter_t code);
        return (code > LETTER_MAX) ? LETTER_BLANK : code;
    endfunction

endpackage

// File: rtl/seg16_scroll_ctrl_if.sv
// Message-load stream, run control and display outputs of the scroll controller.
// master = message source / host side, slave = seg16_scroll_ctrl.
interface seg16_scroll_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();
    import seg16_pkg::*;

    logic                  wr_valid;
    logic                  wr_ready;
    letter_t               wr_letter;
    logic                  wr_last;
    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    letter_t               letter;
    logic [NUM_DIGITS-1:0] digit_en;

    modport master (
        output wr_valid, wr_letter, wr_last, start, abort,
        input  wr_ready, busy, done, letter, digit_en
    );

    modport slave (
        input  wr_valid, wr_letter, wr_last, start, abort,
        output wr_ready, busy, done, letter, digit_en
    );

endinterface

// File: rtl/seg16_scan_timer.sv
// Digit-scan and scroll timebase: per-digit dwell counter, digit index, frame counter.
// o_digit_nxt is the index valid next cycle; o_step marks the last cycle of a scroll step.
module seg16_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int SCROLL_DIV = 250,
    parameter int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [DIG_W-1:0] o_digit_nxt,
    output logic             o_step
);
    localparam int SCAN_W  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int FRAME_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [DIG_W-1:0]   r_digit;
    logic [FRAME_W-1:0] r_frame_cnt;

    logic w_adv;
    logic w_scan_tc;
    logic w_dig_tc;
    logic w_frame_tc;
    logic w_frame_end;

    assign w_adv       = i_en && !i_clr;
    assign w_scan_tc   = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign w_dig_tc    = (r_digit == DIG_W'(NUM_DIGITS - 1));
    assign w_frame_tc  = (r_frame_cnt == FRAME_W'(SCROLL_DIV - 1));
    assign w_frame_end = w_adv && w_scan_tc && w_dig_tc;
    assign o_step      = w_frame_end && w_frame_tc;

    always_comb begin
        o_digit_nxt = r_digit;
        if (i_clr) begin
            o_digit_nxt = '0;
        end else if (w_adv && w_scan_tc) begin
            o_digit_nxt = w_dig_tc ? '0 : r_digit + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_scan_cnt  <= '0;
            r_digit     <= '0;
            r_frame_cnt <= '0;
        end else if (i_en) begin
            r_scan_cnt <= w_scan_tc ? '0 : r_scan_cnt + 1'b1;
            r_digit    <= o_digit_nxt;
            if (w_frame_end) begin
                r_frame_cnt <= w_frame_tc ? '0 : r_frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg16_scroll_ctrl.sv
// Loads a message over valid/ready, then scrolls it left across multiplexed 16-seg digits.
// Outputs registered, first RUN cycle already shows digit 0; SEG16_SCROLL_LOOP_EN makes scrolling repeat.
module seg16_scroll_ctrl
    import seg16_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_DEPTH  = 16,
    parameter int SCAN_DIV   = 1000,
    parameter int SCROLL_DIV = 250
) (
    input  logic                clk,
    input  logic                rst,
    seg16_scroll_ctrl_if.slave  bus
);
    localparam int LEN_W = $clog2(MSG_DEPTH + 1);
    localparam int IDX_W = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SUM_W = $clog2(MSG_DEPTH + NUM_DIGITS) + 1;

    state_t                r_state;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_offset;
    logic                  r_done;
    letter_t               r_letter;
    logic [NUM_DIGITS-1:0] r_digit_en;
    letter_t               r_buf [MSG_DEPTH];

    logic                  w_wr_acc;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_len_full;
    logic                  w_tmr_en;
    logic                  w_tmr_clr;
    logic [DIG_W-1:0]      w_digit_nxt;
    logic                  w_step;
    logic                  w_last_step;
    logic                  w_fin;
    logic                  w_run_nxt;
    logic [LEN_W-1:0]      w_off_nxt;
    logic                  w_show;
    logic [SUM_W-1:0]      w_sum;
    logic                  w_in_msg;
    letter_t               w_rd_letter;
    logic [NUM_DIGITS-1:0] w_onehot;

    seg16_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .SCROLL_DIV (SCROLL_DIV),
        .DIG_W      (DIG_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_tmr_en),
        .i_clr       (w_tmr_clr),
        .o_digit_nxt (w_digit_nxt),
        .o_step      (w_step)
    );

    assign w_tmr_en    = (r_state == ST_RUN);
    assign w_tmr_clr   = (r_state != ST_RUN);
    assign w_wr_acc    = bus.wr_valid && (r_state != ST_RUN);
    assign w_wr_idx    = (r_state == ST_LOAD) ? r_len[IDX_W-1:0] : '0;
    assign w_len_full  = (r_len == LEN_W'(MSG_DEPTH - 1));
    assign w_last_step = (r_offset == r_len - 1'b1);

`ifdef SEG16_SCROLL_LOOP_EN
    assign w_fin = 1'b0;
`else
    assign w_fin = w_step && w_last_step;
`endif

    // Lookahead of the next cycle's state/offset so the display registers land with RUN.
    always_comb begin
        w_run_nxt = 1'b0;
        if (r_state == ST_IDLE) begin
            w_run_nxt = !bus.wr_valid && bus.start;
        end else if (r_state == ST_RUN) begin
            w_run_nxt = !bus.abort && (r_len != '0) && !w_fin;
        end
    end

    always_comb begin
        w_off_nxt = '0;
        if (r_state == ST_RUN) begin
            if (w_step) begin
                w_off_nxt = w_last_step ? '0 : r_offset + 1'b1;
            end else begin
                w_off_nxt = r_offset;
            end
        end
    end

    assign w_show      = w_run_nxt && (r_len != '0);
    assign w_sum       = SUM_W'(w_off_nxt) + SUM_W'(w_digit_nxt);
    assign w_in_msg    = (w_sum < SUM_W'(r_len));
    assign w_rd_letter = r_buf[w_sum[IDX_W-1:0]];
    assign w_onehot    = NUM_DIGITS'(1) << w_digit_nxt;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_buf[w_wr_idx] <= sanitize_letter(bus.wr_letter);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_offset   <= '0;
            r_done     <= 1'b0;
            r_letter   <= LETTER_BLANK;
            r_digit_en <= '0;
        end else begin
            r_done     <= 1'b0;
            r_offset   <= w_off_nxt;
            r_letter   <= (w_show && w_in_msg) ? w_rd_letter : LETTER_BLANK;
            r_digit_en <= w_show ? w_onehot : '0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.wr_valid) begin
                        r_len <= LEN_W'(1);
                        if (!bus.wr_last) begin
                            r_state <= ST_LOAD;
                        end
                    end else if (w_run_nxt) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (bus.wr_valid) begin
                        r_len <= r_len + 1'b1;
                        if (bus.wr_last || w_len_full) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_RUN: begin
                    // Leaving RUN for any reason other than abort is a normal completion.
                    if (!w_run_nxt) begin
                        r_state <= ST_IDLE;
                        r_done  <= !bus.abort;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.wr_ready = (r_state != ST_RUN);
    assign bus.busy     = (r_state == ST_RUN);
    assign bus.done     = r_done;
    assign bus.letter   = r_letter;
    assign bus.digit_en = r_digit_en;

endmodule

// File: tb/tb_seg16_scroll_ctrl.sv
// Bench for seg16_scroll_ctrl: directed scenarios with literal expectations plus random traffic,
// all outputs compared every cycle against a cycle-count based reference model.
module tb_seg16_scroll_ctrl;
    import seg16_pkg::*;

    localparam int ND    = 4;
    localparam int DEPTH = 4;
    localparam int SC    = 2;
    localparam int SD    = 2;
    localparam int CPS   = SC * ND * SD;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg16_scroll_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg16_scroll_ctrl #(
        .NUM_DIGITS (ND),
        .MSG_DEPTH  (DEPTH),
        .SCAN_DIV   (SC),
        .SCROLL_DIV (SD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode, message contents, and cycles elapsed in RUN.
    int m_mode = M_IDLE;
    int m_len  = 0;
    int m_t    = 0;
    bit m_done = 1'b0;
    int m_msg [DEPTH];

    function automatic int san(input int c);
        return (c > 52) ? 0 : c;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_IDLE;
            m_len  = 0;
            m_t    = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (bus.wr_valid) begin
                        m_msg[0] = san(int'(bus.wr_letter));
                        m_len    = 1;
                        m_mode   = bus.wr_last ? M_IDLE : M_LOAD;
                    end else if (bus.start) begin
                        m_mode = M_RUN;
                        m_t    = 0;
                    end
                end
                M_LOAD: begin
                    if (bus.wr_valid) begin
                        m_msg[m_len] = san(int'(bus.wr_letter));
                        m_len++;
                        if (bus.wr_last || m_len == DEPTH) m_mode = M_IDLE;
                    end
                end
                default: begin
                    if (bus.abort) begin
                        m_mode = M_IDLE;
                    end else if (m_len == 0) begin
                        m_mode = M_IDLE;
                        m_done = 1'b1;
                    end else begin
                        m_t++;
                        if (m_t == m_len * CPS) begin
`ifdef SEG16_SCROLL_LOOP_EN
                            m_t = 0;
`else
                            m_mode = M_IDLE;
                            m_done = 1'b1;
`endif
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int off;
            int dig;
            logic [31:0] e_en;
            logic [31:0] e_let;
            off   = m_t / CPS;
            dig   = (m_t / SC) % ND;
            e_en  = 0;
            e_let = 0;
            if (m_mode == M_RUN && m_len > 0) begin
                e_en = 32'(1) << dig;
                if (off + dig < m_len) e_let = m_msg[off + dig];
            end
            chk("model_busy", bus.busy, m_mode == M_RUN);
            chk("model_wr_ready", bus.wr_ready, m_mode != M_RUN);
            chk("model_done", bus.done, m_done);
            chk("model_digit_en", bus.digit_en, e_en);
            chk("model_letter", bus.letter, e_let);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int code, input bit last);
        bus.wr_valid  = 1'b1;
        bus.wr_letter = 6'(code);
        bus.wr_last   = last;
        step();
        bus.wr_valid  = 1'b0;
        bus.wr_last   = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
    endtask

    // Called in RUN cycle 0: checks the first frame against literal letters.
    task automatic frame_chk(input string name, input int l0, input int l1, input int l2, input int l3);
        int exp_l [ND];
        exp_l = '{l0, l1, l2, l3};
        for (int i = 0; i < ND * SC; i++) begin
            chk({name, "_en"}, bus.digit_en, 32'(1) << (i / SC));
            chk({name, "_letter"}, bus.letter, exp_l[i / SC]);
            step();
        end
    endtask

    task automatic run_out(output int n);
        n = 0;
        while (bus.busy && n < 500) begin
            n++;
            step();
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_wr_ready"}, bus.wr_ready, 1);
        chk({name, "_busy"}, bus.busy, 0);
        chk({name, "_done"}, bus.done, 0);
        chk({name, "_letter"}, bus.letter, 0);
        chk({name, "_digit_en"}, bus.digit_en, 0);
    endtask

    initial begin
        int n;
        bus.wr_valid  = 1'b0;
        bus.wr_letter = '0;
        bus.wr_last   = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cmp_en = 1'b1;
        chk_reset_vals("reset");

        // Sanitising and depth limit: 4th write closes the message.
        wr(60, 0); wr(5, 0); wr(6, 0); wr(7, 0);
        chk("t2_ready_after_full", bus.wr_ready, 1);
        go();
        frame_chk("t2_frame", 0, 5, 6, 7);
        do_abort();
        chk("t2_abort_busy", bus.busy, 0);
        wr(8, 0);
        go();
        chk("t2_start_in_load", bus.busy, 0);
        wr(9, 1);
        go();
        frame_chk("t2_newmsg", 8, 9, 0, 0);
        do_abort();

`ifndef SEG16_SCROLL_LOOP_EN
        // Load and full scroll.
        wr(1, 0); wr(2, 0); wr(3, 1);
        go();
        chk("t1_busy_first", bus.busy, 1);
        frame_chk("t1_frame", 1, 2, 3, 0);
        run_out(n);
        chk("t1_run_cycles", n + ND * SC, 48);
        chk("t1_done", bus.done, 1);
        step();
        chk("t1_done_pulse", bus.done, 0);

        // Abort at RUN cycle 10, then replay.
        go();
        repeat (10) step();
        do_abort();
        chk("t4_busy", bus.busy, 0);
        chk("t4_digit_en", bus.digit_en, 0);
        chk("t4_done", bus.done, 0);
        go();
        run_out(n);
        chk("t4_replay_cycles", n, 48);
        chk("t4_replay_done", bus.done, 1);
`endif

        // Write beats start in the same IDLE cycle.
        bus.wr_valid  = 1'b1;
        bus.wr_letter = 6'd9;
        bus.wr_last   = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        bus.start    = 1'b0;
        chk("t3_no_run", bus.busy, 0);
        go();
        chk("t3_letter", bus.letter, 9);
        chk("t3_digit_en", bus.digit_en, 1);
`ifndef SEG16_SCROLL_LOOP_EN
        run_out(n);
        chk("t3_run_cycles", n, 16);
        chk("t3_done", bus.done, 1);
`else
        do_abort();
`endif

        // Reset mid-LOAD loses the message; start then runs an empty message.
        wr(4, 0); wr(5, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("t5_rst");
        go();
        chk("t5_busy", bus.busy, 1);
        chk("t5_digit_en", bus.digit_en, 0);
        step();
        chk("t5_busy_end", bus.busy, 0);
        chk("t5_done", bus.done, 1);

`ifdef SEG16_SCROLL_LOOP_EN
        wr(1, 0); wr(2, 1);
        go();
        chk("t6_letter0", bus.letter, 1);
        repeat (32) step();
        chk("t6_busy_wrap", bus.busy, 1);
        chk("t6_en_wrap", bus.digit_en, 1);
        chk("t6_letter_wrap", bus.letter, 1);
        do_abort();
        chk("t6_abort_busy", bus.busy, 0);
        chk("t6_abort_done", bus.done, 0);
`endif

        // Random traffic, including writes/start during RUN and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            bus.wr_valid  = ($urandom % 3) == 0;
            bus.wr_letter = 6'($urandom % 64);
            bus.wr_last   = ($urandom % 3) == 0;
            bus.start     = ($urandom % 6) == 0;
            bus.abort     = ($urandom % 80) == 0;
            rst           = ($urandom % 500) == 0;
            step();
        end
        bus.wr_valid = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        rst          = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg16_scroll_ctrl.md
Name: seg16_scroll_ctrl

Overview:
- Sequencer that drives one shared 6-bit-code 16-segment letter decoder across NUM_DIGITS multiplexed digits.
- Holds a short message buffer, loaded over a valid/ready stream. On start, scrolls the message left across the digits, then pulses done.
- Sits between the message source (UART/ROM/host FSM) and the decoder. Decoder output plus digit_en feed the board pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions; digit 0 is leftmost.
- MSG_DEPTH, 16, maximum message length in characters.
- SCAN_DIV, 1000, clocks each digit is enabled per scan slot (must be at least 1).
- SCROLL_DIV, 250, full scan frames per scroll step (must be at least 1).

Ports:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- wr_valid, in, 1, write character present.
- wr_ready, out, 1, buffer accepts a write.
- wr_letter, in, 6, character code: 0 = blank, 1..52 = A-Z then a-z.
- wr_last, in, 1, final character of the message.
- start, in, 1, begin scrolling (one cycle is sufficient).
- abort, in, 1, stop scrolling immediately.
- busy, out, 1, high while scrolling.
- done, out, 1, one-cycle pulse when scrolling completes normally.
- letter, out, 6, code to the shared decoder.
- digit_en, out, NUM_DIGITS, one-hot active-high digit enable.

Behaviour:
- Reset: state IDLE, msg_len=0, offset=0, digit index=0, counters=0. wr_ready=1, busy=0, done=0, letter=0, digit_en=0. Buffer contents are don't-care.
- States:
  - IDLE, wr_ready=1:
    - An accepted write (wr_valid & wr_ready) stores at index 0 and sets msg_len=1. If wr_last is clear, go to LOAD; if set, stay in IDLE.
    - start with no write in the same cycle goes to RUN.
    - wr_valid and start in the same cycle: the write wins and start is ignored.
  - LOAD, wr_ready=1:
    - Each accepted write appends at index msg_len and increments msg_len.
    - Return to IDLE when wr_last is accepted or msg_len reaches MSG_DEPTH (that write is stored).
    - start is ignored.
  - RUN, wr_ready=0, busy=1:
    - wr_valid and start are ignored.
- Write sanitising: codes 53..63 are stored as 0 (blank), so the decoder never receives an invalid code from this block.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At terminal count, digit index advances and wraps from NUM_DIGITS-1 to 0.
  - A frame ends when digit index wraps.
  - frame_cnt counts 0..SCROLL_DIV-1; at its terminal count offset increments.
- Outputs:
  - In RUN: digit_en = one-hot(digit index).
  - letter = buf[offset+d] if offset+d < msg_len, else 0, where d is the digit index.
  - letter and digit_en are registered, change in the same cycle, and carry no glitch cycle between digits.
  - Outside RUN: digit_en=0, letter=0.
- Timing:
  - start accepted in cycle T puts the block in RUN from T+1, with offset=0, digit=0 and counters=0.
  - The final step completes when offset would go from msg_len-1 to msg_len. The block then returns to IDLE, and done=1 in the first IDLE cycle.
  - RUN lasts exactly msg_len*SCROLL_DIV*NUM_DIGITS*SCAN_DIV cycles.
- Empty message: start with msg_len=0 enters RUN for one cycle with digit_en=0, then returns to IDLE with a done pulse.
- abort in RUN: IDLE next cycle, no done, msg_len retained so start replays the message. abort outside RUN has no effect.
- Reset mid-RUN or mid-LOAD returns everything to the reset values; the message is lost (msg_len=0).

Optional Feature:
- Macro: SEG16_SCROLL_LOOP_EN.
- Defined: on reaching the final step, offset wraps to 0 and RUN continues indefinitely. done never pulses; only abort or rst leaves RUN.
- Undefined: single pass with a done pulse, as specified above.

Decomposition:
- Package/header seg16_pkg:
  - LETTER_W=6, LETTER_BLANK=0, LETTER_MAX=52.
  - State encodings ST_IDLE, ST_LOAD, ST_RUN.
  - Shared by this block and future message sources.
- One sub-module, seg16_scan_timer: scan_cnt, digit index, frame_cnt and the step/frame-end strobes, with an enable and a synchronous clear.
- The top level holds the FSM, buffer, offset and output registers.

Test Plan (NUM_DIGITS=4, SCAN_DIV=2, SCROLL_DIV=2 unless stated):
1. Load and full scroll: write 1,2,3 (last on 3), then start.
   - busy high for 48 cycles, then done pulse.
   - At offset 0, digit_en 0001/0010/0100/1000 shows letter 1,2,3,0 respectively, each for 2 cycles.
2. Sanitising and overflow: MSG_DEPTH=4, write 60,5,6,7,8 without last.
   - Stored 0,5,6,7; return to IDLE after the 4th write.
   - The 5th write is accepted in IDLE as a new message start with msg_len=1.
3. Handshake priority: assert wr_valid=1 (letter 9, last) and start in the same IDLE cycle.
   - Write stored, no RUN. A later start scrolls letter 9 for 16 cycles.
4. Abort then replay: start a 3-char message, abort at cycle 10 of RUN.
   - Next cycle busy=0, digit_en=0, done=0.
   - A second start runs the full 48 cycles and pulses done.
5. Reset and empty message:
   - rst mid-LOAD, then start: 1-cycle busy, done pulse, digit_en stays 0.
   - Checks all reset values.
6. SEG16_SCROLL_LOOP_EN build, 2-char message:
   - After 32 cycles offset returns to 0 and digit 0 shows the first char again; done never asserts.
   - abort exits RUN.
